// File: rtl/multi_edge_detector.sv
// Per-channel synchronise / optional debounce / edge pulse / sticky flag block.
// Define EDGE_DEBOUNCE_EN to build a DB_CYCLES-deep debounce filter per channel.
module multi_edge_detector #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] sign_in,
  input  logic [1:0]    edge_sel,
  input  logic [CH-1:0] evt_clr,
  output logic [CH-1:0] pulse_out_p,
  output logic [CH-1:0] pulse_out_n,
  output logic [CH-1:0] evt_flag,
  output logic          irq
);

  // Refuse to elaborate configurations the channel logic cannot honour.
  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("multi_edge_detector: CH must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_edge_detector: SYNC_STAGES must be at least 2");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("multi_edge_detector: DB_CYCLES must be at least 2");
  end

  logic [CH-1:0] sync_out;
  logic [CH-1:0] filt;
  logic [CH-1:0] filt_d_reg;
  logic [CH-1:0] pulse_p_reg;
  logic [CH-1:0] pulse_n_reg;
  logic [CH-1:0] flag_reg;
  logic [CH-1:0] flag_next;
  logic [CH-1:0] flag_set;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], sign_in[gi]};
        end
      end

      assign sync_out[gi] = sync_reg[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
      localparam int CNT_W = $clog2(DB_CYCLES);

      logic [CNT_W-1:0] db_cnt_reg;
      logic             f_reg;

      // f only moves once the synchronised level has disagreed with it
      // on DB_CYCLES consecutive edges; any agreement restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt_reg <= '0;
          f_reg      <= 1'b0;
        end else if (sync_out[gi] == f_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
          db_cnt_reg <= '0;
          f_reg      <= sync_out[gi];
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end

      assign filt[gi] = f_reg;
`else
      assign filt[gi] = sync_out[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_d_reg  <= '0;
      pulse_p_reg <= '0;
      pulse_n_reg <= '0;
    end else begin
      filt_d_reg  <= filt;
      pulse_p_reg <= filt & ~filt_d_reg;
      pulse_n_reg <= ~filt & filt_d_reg;
    end
  end

  // Set wins over a coincident clear so no event is lost.
  always_comb begin
    flag_set  = (pulse_p_reg & {CH{edge_sel[0]}}) | (pulse_n_reg & {CH{edge_sel[1]}});
    flag_next = (flag_reg & ~evt_clr) | flag_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg <= '0;
    end else begin
      flag_reg <= flag_next;
    end
  end

  assign pulse_out_p = pulse_p_reg;
  assign pulse_out_n = pulse_n_reg;
  assign evt_flag    = flag_reg;
  assign irq         = |flag_reg;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed self-checking bench for multi_edge_detector at default parameters.
module tb_multi_edge_detector;

  localparam int CH = 4;
`ifdef EDGE_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] sign_in;
  logic [1:0]    edge_sel;
  logic [CH-1:0] evt_clr;
  logic [CH-1:0] pulse_out_p;
  logic [CH-1:0] pulse_out_n;
  logic [CH-1:0] evt_flag;
  logic          irq;

  int checks = 0;
  int errors = 0;

  multi_edge_detector #(.CH(CH), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sign_in     (sign_in),
    .edge_sel    (edge_sel),
    .evt_clr     (evt_clr),
    .pulse_out_p (pulse_out_p),
    .pulse_out_n (pulse_out_n),
    .evt_flag    (evt_flag),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%h", tag, obs);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    sign_in  = '0;
    edge_sel = 2'b00;
    evt_clr  = '0;
    step(3);
    check_val("rst_pulse_p", 32'(pulse_out_p), 32'h0);
    check_val("rst_pulse_n", 32'(pulse_out_n), 32'h0);
    check_val("rst_flag",    32'(evt_flag),    32'h0);
    check_val("rst_irq",     32'(irq),         32'h0);
    rst_n = 1'b1;
    step(2);

    // Single rising edge on channel 0, flags suppressed.
    sign_in = 4'b0001;
    step(LAT - 1);
    check_val("ch0_rise_early", 32'(pulse_out_p), 32'h0);
    step(1);
    check_val("ch0_rise_p", 32'(pulse_out_p), 32'h1);
    check_val("ch0_rise_n", 32'(pulse_out_n), 32'h0);
    step(1);
    check_val("ch0_rise_end",  32'(pulse_out_p), 32'h0);
    check_val("sel00_noflag",  32'(evt_flag),    32'h0);
    sign_in = 4'b0000;
    step(LAT);
    check_val("ch0_fall_n", 32'(pulse_out_n), 32'h1);
    check_val("ch0_fall_p", 32'(pulse_out_p), 32'h0);
    step(1);
    check_val("ch0_fall_end", 32'(pulse_out_n), 32'h0);
    step(2);

    // All channels together.
    sign_in = 4'b1111;
    step(LAT);
    check_val("all_rise_p", 32'(pulse_out_p), 32'hf);
    step(1);
    check_val("all_rise_end", 32'(pulse_out_p), 32'h0);
    step(1);
    sign_in = 4'b0000;
    step(LAT);
    check_val("all_fall_n", 32'(pulse_out_n), 32'hf);
    step(1);
    check_val("all_fall_end", 32'(pulse_out_n), 32'h0);

    // Rising-only flags on channel 2, then clear against a new rising event.
    edge_sel = 2'b01;
    sign_in  = 4'b0100;
    step(LAT);
    check_val("ch2_rise_p", 32'(pulse_out_p), 32'h4);
    step(1);
    check_val("ch2_flag", 32'(evt_flag), 32'h4);
    check_val("ch2_irq",  32'(irq),      32'h1);
    step(1);
    sign_in = 4'b0000;
    step(LAT);
    check_val("ch2_fall_n", 32'(pulse_out_n), 32'h4);
    step(1);
    check_val("ch2_flag_hold", 32'(evt_flag), 32'h4);
    sign_in = 4'b0100;
    step(LAT);
    check_val("ch2_rise2_p", 32'(pulse_out_p), 32'h4);
    evt_clr = 4'b0100;
    step(1);
    evt_clr = 4'b0000;
    check_val("clr_vs_set", 32'(evt_flag), 32'h4);
    evt_clr = 4'b0100;
    step(1);
    evt_clr = 4'b0000;
    check_val("clr_flag", 32'(evt_flag), 32'h0);
    check_val("clr_irq",  32'(irq),      32'h0);

    // Falling-only flags.
    edge_sel = 2'b10;
    sign_in  = 4'b0000;
    step(LAT);
    check_val("sel10_pulse_n",    32'(pulse_out_n), 32'h4);
    check_val("sel10_flag_early", 32'(evt_flag),    32'h0);
    step(1);
    check_val("sel10_flag", 32'(evt_flag), 32'h4);
    evt_clr = 4'b0100;
    step(1);
    evt_clr = 4'b0000;
    check_val("sel10_clr", 32'(evt_flag), 32'h0);

    // Both edges, then select 00 holds the existing flag.
    edge_sel = 2'b11;
    sign_in  = 4'b0010;
    step(LAT + 1);
    check_val("sel11_rise_flag", 32'(evt_flag), 32'h2);
    evt_clr = 4'b0010;
    step(1);
    evt_clr = 4'b0000;
    check_val("sel11_clr", 32'(evt_flag), 32'h0);
    sign_in = 4'b0000;
    step(LAT + 1);
    check_val("sel11_fall_flag", 32'(evt_flag), 32'h2);
    edge_sel = 2'b00;
    sign_in  = 4'b1010;
    step(LAT);
    check_val("sel00_pulse_p", 32'(pulse_out_p), 32'ha);
    step(1);
    check_val("sel00_hold", 32'(evt_flag), 32'h2);
    sign_in = 4'b0000;
    evt_clr = 4'b1111;
    step(1);
    evt_clr = 4'b0000;
    step(LAT + 2);

    // Input high across reset, then reset in the middle of a pulse.
    edge_sel = 2'b11;
    sign_in  = 4'b0011;
    rst_n    = 1'b0;
    #1;
    check_val("rst_async_p", 32'(pulse_out_p), 32'h0);
    step(3);
    rst_n = 1'b1;
    step(LAT - 1);
    check_val("rel_rise_early", 32'(pulse_out_p), 32'h0);
    step(1);
    check_val("rel_rise_p", 32'(pulse_out_p), 32'h3);
    step(1);
    check_val("rel_rise_end", 32'(pulse_out_p), 32'h0);
    check_val("rel_flag",     32'(evt_flag),    32'h3);
    sign_in = 4'b0000;
    step(LAT);
    check_val("pre_rst_n", 32'(pulse_out_n), 32'h3);
    rst_n = 1'b0;
    #1;
    check_val("midrst_p",    32'(pulse_out_p), 32'h0);
    check_val("midrst_n",    32'(pulse_out_n), 32'h0);
    check_val("midrst_flag", 32'(evt_flag),    32'h0);
    check_val("midrst_irq",  32'(irq),         32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);

`ifdef EDGE_DEBOUNCE_EN
    begin
      logic [CH-1:0] seen;
      seen    = '0;
      sign_in = 4'b0001;
      step(3);
      sign_in = 4'b0000;
      for (int i = 0; i < 12; i++) begin
        step(1);
        seen = seen | pulse_out_p | pulse_out_n;
      end
      check_val("db_glitch", 32'(seen), 32'h0);
    end
    sign_in = 4'b0001;
    step(6);
    check_val("db_early", 32'(pulse_out_p), 32'h0);
    sign_in = 4'b0000;
    step(1);
    check_val("db_rise_p", 32'(pulse_out_p), 32'h1);
    step(1);
    check_val("db_rise_end", 32'(pulse_out_p), 32'h0);
    step(12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
